// File: rtl/sl_receiver.sv
// SL two-wire line receiver: decodes sl0/sl1 low pulses into odd-parity words behind a data/status register port.
// Optional glitch filter on the synchronized lines is enabled by defining SL_RX_GLITCH_FILTER_EN.
module sl_receiver #(
    parameter int unsigned BIT_CLKS     = 8,
    parameter int unsigned TIMEOUT_BITS = 4,
    parameter int unsigned FILTER_LEN   = 3,
    parameter int unsigned MAX_BITS     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sl0,
    input  logic        sl1,
    input  logic [31:0] d_in,
    input  logic        addr,
    input  logic        wr_en,
    output logic [31:0] d_out,
    output logic        word_ready
);
    localparam int unsigned CNT_W = $clog2(MAX_BITS + 1);
    localparam int unsigned GAP_W = 16;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, PULSE0, PULSE1, GAP, STOP} state_t;

    state_t              state, state_nxt;
    logic [1:0]          sync_meta, sync_q, line;   // bit 0 = sl0, bit 1 = sl1
    logic [MAX_BITS-1:0] shift_q;
    logic [CNT_W-1:0]    rx_cnt;
    logic [GAP_W-1:0]    gap_cnt, gap_limit;
    logic [5:0]          word_len, cfg_len, bit_cnt, data_cnt;
    logic [2:0]          word_mode, cfg_mode;
    logic [31:0]         data_q;
    logic                ready, parity_err, length_err, framing_err, overflow, overrun;
    logic                shift_en, shift_bit, word_done, timeout, busy;
    logic                unused_d_in;

    assign unused_d_in = ^{d_in[31:11], d_in[6]};

    // NOTE: sequential state is always updated with non-blocking assignments so every flop samples pre-edge values.
    // Synchronizers reset low so the FSM waits for lines that are really idle, dropping a word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {sl1, sl0};
            sync_q    <= sync_meta;
        end
    end

`ifdef SL_RX_GLITCH_FILTER_EN
    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    logic [1:0]        filt_q;
    logic [FILT_W-1:0] filt_cnt [2];

    // A line only changes once its new level has been seen FILTER_LEN samples in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= '0;
            filt_cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FILT_W'(FILTER_LEN - 1)) begin
                    filt_q[i]   <= sync_q[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end
    assign line = filt_q;
`else
    localparam int unsigned unused_filter_len = FILTER_LEN;
    assign line = sync_q;
`endif

    assign gap_limit = GAP_W'(TIMEOUT_BITS * BIT_CLKS) << word_mode;
    assign data_cnt  = 6'(rx_cnt - 1'b1);
    assign busy      = (state == PULSE0) || (state == PULSE1) || (state == GAP) || (state == STOP);

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        word_done = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            WAIT_IDLE: if (line == 2'b11) state_nxt = IDLE;
            IDLE, GAP: begin
                if (line == 2'b00) begin
                    state_nxt = (state == IDLE) ? WAIT_IDLE : STOP;
                    word_done = (state == GAP);
                end else if (!line[0]) begin
                    state_nxt = PULSE0;
                    shift_en  = 1'b1;
                end else if (!line[1]) begin
                    state_nxt = PULSE1;
                    shift_en  = 1'b1;
                    shift_bit = 1'b1;
                end else if (state == GAP && gap_cnt == gap_limit - 1'b1) begin
                    state_nxt = IDLE;
                    timeout   = 1'b1;
                end
            end
            PULSE0: begin
                if (line[0])       state_nxt = GAP;
                else if (!line[1]) begin state_nxt = STOP; word_done = 1'b1; end
            end
            PULSE1: begin
                if (line[1])       state_nxt = GAP;
                else if (!line[0]) begin state_nxt = STOP; word_done = 1'b1; end
            end
            STOP:    if (line == 2'b11) state_nxt = IDLE;
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    // Word assembly; configuration is latched at the first bit so mid-word writes affect the next word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            rx_cnt    <= '0;
            gap_cnt   <= '0;
            word_len  <= '0;
            word_mode <= '0;
        end else begin
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (shift_en) begin
                if (state == IDLE) begin
                    shift_q   <= MAX_BITS'(shift_bit);
                    rx_cnt    <= CNT_W'(1);
                    word_len  <= cfg_len;
                    word_mode <= (cfg_mode > 3'd5) ? 3'd5 : cfg_mode;
                end else if (rx_cnt != CNT_W'(MAX_BITS)) begin
                    shift_q <= {shift_q[MAX_BITS-2:0], shift_bit};
                    rx_cnt  <= rx_cnt + 1'b1;
                end
            end
        end
    end

    // Register port and status flags; completion is applied last so it wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_len     <= '0;
            cfg_mode    <= '0;
            data_q      <= '0;
            bit_cnt     <= '0;
            ready       <= 1'b0;
            parity_err  <= 1'b0;
            length_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (wr_en && addr) begin
                cfg_len  <= d_in[5:0];
                cfg_mode <= d_in[9:7];
                if (d_in[10]) begin
                    ready       <= 1'b0;
                    parity_err  <= 1'b0;
                    length_err  <= 1'b0;
                    framing_err <= 1'b0;
                    overflow    <= 1'b0;
                    overrun     <= 1'b0;
                end
            end
            if (shift_en && state != IDLE && rx_cnt == CNT_W'(MAX_BITS)) overflow <= 1'b1;
            if (timeout) framing_err <= 1'b1;
            if (word_done) begin
                if (rx_cnt == '0) begin
                    framing_err <= 1'b1;
                end else begin
                    data_q     <= 32'(shift_q >> 1);
                    bit_cnt    <= data_cnt;
                    parity_err <= ~^shift_q;
                    length_err <= (word_len != '0) && (data_cnt != word_len);
                    ready      <= 1'b1;
                    if (ready) overrun <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        d_out = data_q;
        if (addr) begin
            d_out = {2'b00, bit_cnt, 1'b0, overrun, overflow, framing_err, length_err,
                     parity_err, ready, busy, 6'b0, cfg_mode, 1'b0, cfg_len};
        end
    end

    assign word_ready = ready;

endmodule
